// File: rtl/mul_pkg.sv
// Shared types for the shift-add multiplier: FSM state encoding and counter sizing.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mul_state_e;

    // Iteration counter width; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/carry_lookahead_adder.sv
// Block carry-lookahead adder: ripple inside each BLOCK_SIZE block, lookahead across blocks.
// Purely combinational, zero latency, no handshake.
module carry_lookahead_adder #(
    parameter int N          = 32,
    parameter int BLOCK_SIZE = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);

    localparam int NB = N / BLOCK_SIZE;

    logic [N-1:0]  g;
    logic [N-1:0]  pr;
    logic [N-1:0]  c;
    logic [NB-1:0] bg;
    logic [NB-1:0] bp;
    logic [NB:0]   bc;

    always_comb begin
        g  = a & b;
        pr = a ^ b;
        bg = '0;
        bp = '1;
        bc = '0;
        c  = '0;

        // Group generate/propagate, accumulated from the block's LSB upward.
        for (int k = 0; k < NB; k++) begin
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                bg[k] = g[k*BLOCK_SIZE + i] | (pr[k*BLOCK_SIZE + i] & bg[k]);
                bp[k] = bp[k] & pr[k*BLOCK_SIZE + i];
            end
        end

        bc[0] = cin;
        for (int k = 0; k < NB; k++) begin
            bc[k+1] = bg[k] | (bp[k] & bc[k]);
        end

        for (int k = 0; k < NB; k++) begin
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                if (i == 0) begin
                    c[k*BLOCK_SIZE] = bc[k];
                end else begin
                    c[k*BLOCK_SIZE + i] = g[k*BLOCK_SIZE + i - 1]
                                        | (pr[k*BLOCK_SIZE + i - 1] & c[k*BLOCK_SIZE + i - 1]);
                end
            end
        end

        s    = pr ^ c;
        cout = bc[NB];
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned NxN->2N multiplier, one shift-add step per clock; out_valid N+1 edges after accept.
// No operand queueing: in_ready low while busy; product held stable while out_ready is low.
module shift_add_multiplier
    import mul_pkg::*;
#(
    parameter int N          = 32,
    parameter int BLOCK_SIZE = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] p
);

    localparam int CW = cnt_width(N);

    if ((N % BLOCK_SIZE != 0) || (N < 2)) begin : g_bad_param
        $error("shift_add_multiplier: N must be >= 2 and a multiple of BLOCK_SIZE");
    end

    mul_state_e     state;
    logic [N-1:0]   mcand;
    logic [2*N-1:0] prod;
    logic [CW-1:0]  cnt;

    logic [N-1:0]   addend;
    logic [N-1:0]   sum;
    logic           cout;

    assign addend = prod[0] ? mcand : '0;

    carry_lookahead_adder #(
        .N          (N),
        .BLOCK_SIZE (BLOCK_SIZE)
    ) u_adder (
        .a    (prod[2*N-1:N]),
        .b    (addend),
        .cin  (1'b0),
        .s    (sum),
        .cout (cout)
    );

    assign p = prod;

    // DONE spends its first cycle registering out_valid, so the handshake only
    // completes once out_valid is actually visible to the consumer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            mcand     <= '0;
            prod      <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        mcand    <= a;
                        prod     <= {{N{1'b0}}, b};
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    prod <= {cout, sum, prod[N-1:1]};
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(N - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
